// File: rtl/dnn_pkg.sv
// Shared types and fixed-point helpers for the dense layer engine.
package dnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_BIAS = 2'd2,
        ST_DONE = 2'd3
    } dense_state_t;

    // Width of the intermediate bias/saturation arithmetic; must cover ACC_W.
    localparam int FXP_CALC_W = 64;

    function automatic int acc_width(input int data_w, input int n_in);
        return 2 * data_w + $clog2(n_in) + 1;
    endfunction

    function automatic int bias_base(input int n_out, input int n_in);
        return n_out * n_in;
    endfunction

    function automatic logic signed [FXP_CALC_W-1:0] sat_fxp(
        input logic signed [FXP_CALC_W-1:0] v,
        input int                           data_w
    );
        logic signed [FXP_CALC_W-1:0] hi;
        logic signed [FXP_CALC_W-1:0] lo;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/fxp_mac.sv
// Signed multiply-accumulate register; kept separate so it can be retimed into a DSP slice.
module fxp_mac #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 34
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);

    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0] prod;

    assign prod = PW'(a) * PW'(b);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/dense_layer_seq.sv
// Fully-connected fixed-point layer computed neuron by neuron on one shared MAC.
//   state   | meaning
//   IDLE    | waiting for ap_start && in_vld; parameter writes accepted
//   MAC     | accumulate w[j][i]*x[i], one input per cycle
//   BIAS    | shift, add bias, saturate, ReLU, write slot j
//   DONE    | one-cycle ap_done/ap_ready/out_vld pulse
module dense_layer_seq
    import dnn_pkg::*;
#(
    parameter  int DATA_W    = 16,
    parameter  int FRAC_BITS = 10,
    parameter  int N_IN      = 2,
    parameter  int N_OUT     = 1,
    parameter  int RELU      = 0,
    localparam int WA_W      = $clog2(N_OUT * (N_IN + 1))
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      ap_start,
    output logic                      ap_done,
    output logic                      ap_idle,
    output logic                      ap_ready,
    input  logic                      in_vld,
    input  logic [N_IN*DATA_W-1:0]    in_data,
    input  logic                      wgt_we,
    input  logic [WA_W-1:0]           wgt_addr,
    input  logic [DATA_W-1:0]         wgt_data,
    output logic [N_OUT*DATA_W-1:0]   out_data,
    output logic                      out_vld
);

    localparam int ACC_W     = acc_width(DATA_W, N_IN);
    localparam int N_PAR     = N_OUT * (N_IN + 1);
    localparam int BIAS_BASE = bias_base(N_OUT, N_IN);
    localparam int IW        = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int JW        = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    dense_state_t              state;
    logic [IW-1:0]             i_cnt;
    logic [JW-1:0]             j_cnt;
    logic signed [DATA_W-1:0]  x_arr   [N_IN];
    logic signed [DATA_W-1:0]  par_mem [N_PAR];
    logic signed [DATA_W-1:0]  mac_w;
    logic signed [DATA_W-1:0]  mac_x;
    logic signed [DATA_W-1:0]  bias_val;
    logic signed [DATA_W-1:0]  y_new;
    logic signed [ACC_W-1:0]   acc;
    logic signed [FXP_CALC_W-1:0] r_full;
    logic signed [FXP_CALC_W-1:0] r_sat;
    logic                      mac_clr;
    logic                      mac_en;

    assign mac_w    = par_mem[WA_W'(int'(j_cnt) * N_IN + int'(i_cnt))];
    assign mac_x    = x_arr[i_cnt];
    assign bias_val = par_mem[WA_W'(BIAS_BASE + int'(j_cnt))];
    assign mac_en   = (state == ST_MAC);
    assign mac_clr  = (state == ST_IDLE) || (state == ST_BIAS);

    fxp_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .clr      (mac_clr),
        .en       (mac_en),
        .a        (mac_w),
        .b        (mac_x),
        .acc      (acc)
    );

    // Realign once on the full sum so truncation error is not compounded per product.
    always_comb begin
        r_full = (FXP_CALC_W'(acc) >>> FRAC_BITS) + FXP_CALC_W'(bias_val);
        r_sat  = sat_fxp(r_full, DATA_W);
        if (RELU != 0 && r_sat < 0) begin
            r_sat = '0;
        end
        y_new = DATA_W'(r_sat);
    end

    // Parameter storage survives reset; writes only land while idle.
    always_ff @(posedge ap_clk) begin
        if (wgt_we && state == ST_IDLE && int'(wgt_addr) < N_PAR) begin
            par_mem[wgt_addr] <= wgt_data;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state    <= ST_IDLE;
            i_cnt    <= '0;
            j_cnt    <= '0;
            ap_done  <= 1'b0;
            ap_ready <= 1'b0;
            out_vld  <= 1'b0;
            ap_idle  <= 1'b1;
            out_data <= '0;
            for (int k = 0; k < N_IN; k++) begin
                x_arr[k] <= '0;
            end
        end else begin
            ap_done  <= 1'b0;
            ap_ready <= 1'b0;
            out_vld  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ap_start && in_vld) begin
                        for (int k = 0; k < N_IN; k++) begin
                            x_arr[k] <= in_data[k*DATA_W +: DATA_W];
                        end
                        i_cnt   <= '0;
                        j_cnt   <= '0;
                        ap_idle <= 1'b0;
                        state   <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (i_cnt == IW'(N_IN - 1)) begin
                        i_cnt <= '0;
                        state <= ST_BIAS;
                    end else begin
                        i_cnt <= i_cnt + IW'(1);
                    end
                end
                ST_BIAS: begin
                    out_data[int'(j_cnt)*DATA_W +: DATA_W] <= y_new;
                    i_cnt <= '0;
                    if (j_cnt == JW'(N_OUT - 1)) begin
                        ap_done  <= 1'b1;
                        ap_ready <= 1'b1;
                        out_vld  <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        j_cnt <= j_cnt + JW'(1);
                        state <= ST_MAC;
                    end
                end
                ST_DONE: begin
                    j_cnt   <= '0;
                    ap_idle <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Directed bench: default, ReLU and 4x3 instances of dense_layer_seq.
module tb_dense_layer_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // default config: N_IN=2, N_OUT=1, RELU=0
    logic        d_start = 0, d_vld = 0, d_we = 0;
    logic [31:0] d_data = '0;
    logic [1:0]  d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic [15:0] d_out;
    logic        d_done, d_idle, d_ready, d_ovld;

    // RELU=1 variant
    logic        r_start = 0, r_vld = 0, r_we = 0;
    logic [31:0] r_data = '0;
    logic [1:0]  r_addr = '0;
    logic [15:0] r_wdata = '0;
    logic [15:0] r_out;
    logic        r_done, r_idle, r_ready, r_ovld;

    // N_IN=4, N_OUT=3
    logic        m_start = 0, m_vld = 0, m_we = 0;
    logic [63:0] m_data = '0;
    logic [3:0]  m_addr = '0;
    logic [15:0] m_wdata = '0;
    logic [47:0] m_out;
    logic        m_done, m_idle, m_ready, m_ovld;

    dense_layer_seq #(.DATA_W(16), .FRAC_BITS(10), .N_IN(2), .N_OUT(1), .RELU(0)) u_def (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(d_start), .ap_done(d_done),
        .ap_idle(d_idle), .ap_ready(d_ready), .in_vld(d_vld), .in_data(d_data),
        .wgt_we(d_we), .wgt_addr(d_addr), .wgt_data(d_wdata), .out_data(d_out), .out_vld(d_ovld));

    dense_layer_seq #(.DATA_W(16), .FRAC_BITS(10), .N_IN(2), .N_OUT(1), .RELU(1)) u_relu (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(r_start), .ap_done(r_done),
        .ap_idle(r_idle), .ap_ready(r_ready), .in_vld(r_vld), .in_data(r_data),
        .wgt_we(r_we), .wgt_addr(r_addr), .wgt_data(r_wdata), .out_data(r_out), .out_vld(r_ovld));

    dense_layer_seq #(.DATA_W(16), .FRAC_BITS(10), .N_IN(4), .N_OUT(3), .RELU(0)) u_multi (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(m_start), .ap_done(m_done),
        .ap_idle(m_idle), .ap_ready(m_ready), .in_vld(m_vld), .in_data(m_data),
        .wgt_we(m_we), .wgt_addr(m_addr), .wgt_data(m_wdata), .out_data(m_out), .out_vld(m_ovld));

    logic signed [15:0] mw [15] = '{16'sd512, -16'sd256, 16'sd1024, 16'sd2048,
                                    -16'sd1024, 16'sd1024, 16'sd2048, -16'sd4096,
                                    16'sd300, 16'sd7, -16'sd13, 16'sd1000,
                                    16'sd100, -16'sd50, 16'sd3};
    // x = {0.25, -0.5, 2.0, 1.0}; y = {573, -1074, 100}
    localparam logic [63:0] MX1 = {16'h0100, 16'hFE00, 16'h0800, 16'h0400};
    localparam logic [47:0] MY1 = {16'h023D, 16'hFBCE, 16'h0064};
    localparam logic [47:0] MY0 = {16'h0003, 16'hFFCE, 16'h0064};

    task automatic d_write(input logic [1:0] a, input logic [15:0] v);
        @(negedge clk); d_we = 1; d_addr = a; d_wdata = v;
        @(negedge clk); d_we = 0;
    endtask

    task automatic r_write(input logic [1:0] a, input logic [15:0] v);
        @(negedge clk); r_we = 1; r_addr = a; r_wdata = v;
        @(negedge clk); r_we = 0;
    endtask

    task automatic m_write(input logic [3:0] a, input logic [15:0] v);
        @(negedge clk); m_we = 1; m_addr = a; m_wdata = v;
        @(negedge clk); m_we = 0;
    endtask

    task automatic d_run(input logic [31:0] x, output logic [15:0] y, output int lat,
                         output logic rdy, output logic ovld, output int idle_lo);
        @(negedge clk); d_data = x; d_vld = 1; d_start = 1;
        @(posedge clk);
        lat = 0; idle_lo = 0; rdy = 0; ovld = 0; y = '0;
        while (lat < 40) begin
            @(negedge clk);
            d_start = 0; d_vld = 0;
            lat++;
            if (!d_idle) idle_lo++;
            if (d_done) begin
                rdy = d_ready; ovld = d_ovld; y = d_out;
                break;
            end
        end
    endtask

    task automatic r_run(input logic [31:0] x, output logic [15:0] y, output int lat);
        @(negedge clk); r_data = x; r_vld = 1; r_start = 1;
        @(posedge clk);
        lat = 0; y = '0;
        while (lat < 40) begin
            @(negedge clk);
            r_start = 0; r_vld = 0;
            lat++;
            if (r_done) begin y = r_out; break; end
        end
    endtask

    task automatic m_run(input logic [63:0] x, output logic [47:0] y, output int lat,
                         output logic [47:0] early);
        @(negedge clk); m_data = x; m_vld = 1; m_start = 1;
        @(posedge clk);
        lat = 0; y = '0; early = '0;
        while (lat < 60) begin
            @(negedge clk);
            m_start = 0; m_vld = 0;
            lat++;
            if (lat == 1) early = m_out;
            if (m_done) begin y = m_out; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++; if (d_idle !== 1'b1) begin n_err++; $display("FAIL reset_idle got=%b exp=1", d_idle); end
        n_vec++; if ({d_done, d_ready, d_ovld} !== 3'b000) begin n_err++; $display("FAIL reset_pulses got=%b exp=000", {d_done, d_ready, d_ovld}); end
        n_vec++; if (d_out !== 16'h0000) begin n_err++; $display("FAIL reset_out got=%h exp=0000", d_out); end
        n_vec++; if (m_out !== 48'h0) begin n_err++; $display("FAIL reset_mout got=%h exp=0", m_out); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] y; int lat; logic rdy; logic ov; int il;
        d_write(2'd0, 16'hFEE0);   // -288
        d_write(2'd1, 16'd304);
        d_write(2'd2, 16'd157);
        d_run({16'd1024, 16'd1024}, y, lat, rdy, ov, il);
        n_vec++; if (y !== 16'h00AD) begin n_err++; $display("FAIL basic_out got=%h exp=00ad", y); end
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL basic_latency got=%0d exp=4", lat); end
        n_vec++; if ({rdy, ov} !== 2'b11) begin n_err++; $display("FAIL basic_ready_vld got=%b exp=11", {rdy, ov}); end
        n_vec++; if (il !== 4) begin n_err++; $display("FAIL basic_idle_low got=%0d exp=4", il); end
        @(negedge clk);
        n_vec++; if ({d_done, d_ready, d_ovld, d_idle} !== 4'b0001) begin n_err++; $display("FAIL basic_after_done got=%b exp=0001", {d_done, d_ready, d_ovld, d_idle}); end
        n_vec++; if (d_out !== 16'h00AD) begin n_err++; $display("FAIL basic_hold got=%h exp=00ad", d_out); end
    endtask

    task automatic test_relu();
        logic [15:0] y; int lat; logic rdy; logic ov; int il;
        r_write(2'd0, 16'hFEE0);
        r_write(2'd1, 16'd304);
        r_write(2'd2, 16'd157);
        d_run({16'd0, 16'd4096}, y, lat, rdy, ov, il);
        n_vec++; if (y !== 16'hFC1D) begin n_err++; $display("FAIL relu_off got=%h exp=fc1d", y); end
        r_run({16'd0, 16'd4096}, y, lat);
        n_vec++; if (y !== 16'h0000) begin n_err++; $display("FAIL relu_clamp got=%h exp=0000", y); end
        r_run({16'd1024, 16'd1024}, y, lat);
        n_vec++; if (y !== 16'h00AD) begin n_err++; $display("FAIL relu_pos got=%h exp=00ad", y); end
    endtask

    task automatic test_no_start();
        int busy = 0;
        @(negedge clk); d_start = 1; d_vld = 0; d_data = {16'd1024, 16'd1024};
        repeat (5) begin
            @(negedge clk);
            if (!d_idle || d_done || d_ovld) busy++;
        end
        d_start = 0;
        n_vec++; if (busy !== 0) begin n_err++; $display("FAIL nostart_activity got=%0d exp=0", busy); end
        n_vec++; if (d_out !== 16'hFC1D) begin n_err++; $display("FAIL nostart_out got=%h exp=fc1d", d_out); end
    endtask

    task automatic test_wgt_during_mac();
        logic [15:0] y; int lat = 0; logic rdy; logic ov; int il;
        @(negedge clk); d_data = {16'd1024, 16'd1024}; d_vld = 1; d_start = 1;
        @(posedge clk);
        @(negedge clk); d_start = 0; d_vld = 0; d_we = 1; d_addr = 2'd0; d_wdata = 16'd9999;
        @(negedge clk); d_we = 0;
        lat = 2;
        while (!d_done && lat < 40) begin @(negedge clk); lat++; end
        n_vec++; if (d_out !== 16'h00AD || !d_done) begin n_err++; $display("FAIL wgt_mac_out got=%h done=%b exp=00ad", d_out, d_done); end
        d_run({16'd1024, 16'd1024}, y, lat, rdy, ov, il);
        n_vec++; if (y !== 16'h00AD) begin n_err++; $display("FAIL wgt_mac_retained got=%h exp=00ad", y); end
    endtask

    task automatic test_trunc_sat();
        logic [15:0] y; int lat; logic rdy; logic ov; int il;
        d_write(2'd0, 16'hFFFF);
        d_write(2'd1, 16'd0);
        d_write(2'd2, 16'd0);
        d_run({16'd0, 16'd1}, y, lat, rdy, ov, il);
        n_vec++; if (y !== 16'hFFFF) begin n_err++; $display("FAIL trunc_neg got=%h exp=ffff", y); end
        d_write(2'd0, 16'h7FFF);
        d_run({16'd0, 16'h7FFF}, y, lat, rdy, ov, il);
        n_vec++; if (y !== 16'h7FFF) begin n_err++; $display("FAIL sat_pos got=%h exp=7fff", y); end
        d_write(2'd0, 16'h8000);
        d_run({16'd0, 16'h7FFF}, y, lat, rdy, ov, il);
        n_vec++; if (y !== 16'h8000) begin n_err++; $display("FAIL sat_neg got=%h exp=8000", y); end
    endtask

    task automatic test_multi();
        logic [47:0] y; logic [47:0] early; int lat;
        for (int k = 0; k < 15; k++) m_write(4'(k), mw[k]);
        m_run(MX1, y, lat, early);
        n_vec++; if (y !== MY1) begin n_err++; $display("FAIL multi_out got=%h exp=%h", y, MY1); end
        n_vec++; if (lat !== 16) begin n_err++; $display("FAIL multi_latency got=%0d exp=16", lat); end
        m_run(64'h0, y, lat, early);
        n_vec++; if (early !== MY1) begin n_err++; $display("FAIL multi_hold got=%h exp=%h", early, MY1); end
        n_vec++; if (y !== MY0) begin n_err++; $display("FAIL multi_bias_only got=%h exp=%h", y, MY0); end
    endtask

    task automatic test_back_to_back();
        int cyc = 0; int nd = 0; int t1 = 0; int t2 = 0; int extra = 0;
        logic [47:0] y2 = '0;
        @(negedge clk); m_data = MX1; m_vld = 1; m_start = 1;
        while (nd < 2 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (m_done) begin
                nd++;
                if (nd == 1) t1 = cyc;
                else begin t2 = cyc; y2 = m_out; m_start = 0; m_vld = 0; end
            end
        end
        m_start = 0; m_vld = 0;
        repeat (25) begin @(negedge clk); if (m_done) extra++; end
        n_vec++; if (t1 !== 16) begin n_err++; $display("FAIL b2b_first got=%0d exp=16", t1); end
        n_vec++; if (t2 - t1 !== 17) begin n_err++; $display("FAIL b2b_ii got=%0d exp=17", t2 - t1); end
        n_vec++; if (y2 !== MY1) begin n_err++; $display("FAIL b2b_out got=%h exp=%h", y2, MY1); end
        n_vec++; if (extra !== 0) begin n_err++; $display("FAIL b2b_extra got=%0d exp=0", extra); end
    endtask

    task automatic test_reset_mid();
        logic [47:0] y; logic [47:0] early; int lat; int pulses = 0;
        @(negedge clk); m_data = MX1; m_vld = 1; m_start = 1;
        @(posedge clk);
        @(negedge clk); m_start = 0; m_vld = 0;
        @(negedge clk); rst_n = 1'b0;
        #1;
        n_vec++; if (m_out !== 48'h0) begin n_err++; $display("FAIL rstmid_out got=%h exp=0", m_out); end
        n_vec++; if ({m_idle, m_done, m_ovld} !== 3'b100) begin n_err++; $display("FAIL rstmid_ctrl got=%b exp=100", {m_idle, m_done, m_ovld}); end
        @(negedge clk); rst_n = 1'b1;
        repeat (30) begin @(negedge clk); if (m_ovld || m_done) pulses++; end
        n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL rstmid_pulse got=%0d exp=0", pulses); end
        m_run(MX1, y, lat, early);
        n_vec++; if (y !== MY1) begin n_err++; $display("FAIL rstmid_rerun got=%h exp=%h", y, MY1); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_no_start();
        test_wgt_during_mac();
        test_trunc_sat();
        test_multi();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
